// File: rtl/rx_pkt_pkg.sv
// Shared types and constants for the UART receive packet controller.
package rx_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_HOLD
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CHK  = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;
  localparam int unsigned BUF_AW        = 4;

endpackage

// File: rtl/rx_pkt_buffer.sv
// Packet payload store: DEPTH x 8 register file, one write port, one registered read port.
module rx_pkt_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [7:0] rdata_q, rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    rdata_d = mem_q[raddr];
  end

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rx_packet_controller.sv
// Frames received UART bytes (HEADER, LEN, payload, CHK) into a held packet buffer.
// Optional inter-byte timeout is enabled by defining RX_PKT_TIMEOUT_EN.
module rx_packet_controller
  import rx_pkt_pkg::*;
#(
  parameter logic [7:0]  HEADER      = DEFAULT_HEADER,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Rx_Done_Sig,
  input  logic [7:0] Rx_Data,
  output logic       Rx_En_Sig,
  output logic       Pkt_Ready_Sig,
  output logic [4:0] Pkt_Len,
  input  logic [3:0] Rd_Addr,
  output logic [7:0] Rd_Data,
  input  logic       Pkt_Ack_Sig,
  output logic       Err_Sig,
  output logic [1:0] Err_Code
);

  state_e      state_q, state_d;
  err_e        code_q, code_d;
  logic [7:0]  sum_q, sum_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  len_q, len_d;
  logic        rx_en_q, rx_en_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        buf_we;

`ifdef RX_PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] timer_q, timer_d;
`endif

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    len_d   = len_q;
    err_d   = 1'b0;
    buf_we  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (Rx_Done_Sig && Rx_Data == HEADER) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (Rx_Done_Sig) begin
          if (Rx_Data != 8'd0 && Rx_Data <= 8'(MAX_LEN)) begin
            len_d   = Rx_Data[4:0];
            sum_d   = Rx_Data;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            state_d = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (Rx_Done_Sig) begin
          buf_we = 1'b1;
          sum_d  = sum_q + Rx_Data;
          idx_d  = idx_q + 4'd1;
          if ({1'b0, idx_q} == len_q - 5'd1) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (Rx_Done_Sig) begin
          if (Rx_Data == sum_q) begin
            state_d = ST_HOLD;
          end else begin
            err_d   = 1'b1;
            code_d  = ERR_CHK;
            state_d = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (Pkt_Ack_Sig) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef RX_PKT_TIMEOUT_EN
    // A byte arriving on the expiry cycle takes priority over the timeout.
    timer_d = '0;
    if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CHECK) begin
      if (Rx_Done_Sig) begin
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
        err_d   = 1'b1;
        code_d  = ERR_TMO;
        state_d = ST_IDLE;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
`endif

    rx_en_d = (state_d != ST_HOLD);
    ready_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      code_q  <= ERR_NONE;
      sum_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      rx_en_q <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      rx_en_q <= rx_en_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

`ifdef RX_PKT_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) timer_q <= '0;
    else     timer_q <= timer_d;
  end
`endif

  rx_pkt_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (BUF_AW)
  ) u_buf (
    .clk   (CLK),
    .rst   (RST),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (Rx_Data),
    .raddr (Rd_Addr),
    .rdata (Rd_Data)
  );

  assign Rx_En_Sig     = rx_en_q;
  assign Pkt_Ready_Sig = ready_q;
  assign Pkt_Len       = len_q;
  assign Err_Sig       = err_q;
  assign Err_Code      = code_q;

endmodule

// File: tb/tb_rx_packet_controller.sv
// Directed self-checking bench for rx_packet_controller (timeout cases when RX_PKT_TIMEOUT_EN is defined).
module tb_rx_packet_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_en;
  logic       pkt_ready;
  logic [4:0] pkt_len;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       pkt_ack = 1'b0;
  logic       err;
  logic [1:0] err_code;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  rx_packet_controller #(
    .HEADER      (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CYC (100)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .Rx_Done_Sig   (rx_done),
    .Rx_Data       (rx_data),
    .Rx_En_Sig     (rx_en),
    .Pkt_Ready_Sig (pkt_ready),
    .Pkt_Len       (pkt_len),
    .Rd_Addr       (rd_addr),
    .Rd_Data       (rd_data),
    .Pkt_Ack_Sig   (pkt_ack),
    .Err_Sig       (err),
    .Err_Code      (err_code)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Returns on the falling edge after the consuming rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic read_byte(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    d = rd_data;
  endtask

  task automatic ack_pkt(input string tag);
    @(negedge clk);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    check_eq({tag, "_ready_after_ack"}, 32'(pkt_ready), 32'd0);
    check_eq({tag, "_rxen_after_ack"}, 32'(rx_en), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rxen"},  32'(rx_en),     32'd0);
    check_eq({tag, "_ready"}, 32'(pkt_ready), 32'd0);
    check_eq({tag, "_len"},   32'(pkt_len),   32'd0);
    check_eq({tag, "_rdata"}, 32'(rd_data),   32'd0);
    check_eq({tag, "_err"},   32'(err),       32'd0);
    check_eq({tag, "_code"},  32'(err_code),  32'd0);
  endtask

  initial begin
    logic [7:0] d;
    logic [7:0] f1 [6] = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h63};
    logic [7:0] f2 [5] = '{8'hA5, 8'h02, 8'hFF, 8'h02, 8'h03};

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    check_eq("rxen_before_edge", 32'(rx_en), 32'd0);
    @(negedge clk);
    check_eq("rxen_first_edge", 32'(rx_en), 32'd1);

    // 1: basic frame, read back, Rx_Done ignored in HOLD, ack releases
    foreach (f1[i]) send_byte(f1[i]);
    check_eq("t1_ready", 32'(pkt_ready), 32'd1);
    check_eq("t1_len",   32'(pkt_len),   32'd3);
    check_eq("t1_rxen",  32'(rx_en),     32'd0);
    check_eq("t1_err",   32'(err),       32'd0);
    read_byte(4'd0, d); check_eq("t1_rd0", 32'(d), 32'h10);
    read_byte(4'd1, d); check_eq("t1_rd1", 32'(d), 32'h20);
    read_byte(4'd2, d); check_eq("t1_rd2", 32'(d), 32'h30);
    send_byte(8'hA5);
    check_eq("t1_hold_ignores_done", 32'(pkt_ready), 32'd1);
    ack_pkt("t1");
    @(negedge clk);
    pkt_ack = 1'b1;
    @(negedge clk);
    pkt_ack = 1'b0;
    check_eq("ack_in_idle_no_ready", 32'(pkt_ready), 32'd0);

    // 2: checksum wraps modulo 256
    foreach (f2[i]) send_byte(f2[i]);
    check_eq("t2_ready", 32'(pkt_ready), 32'd1);
    check_eq("t2_len",   32'(pkt_len),   32'd2);
    read_byte(4'd0, d); check_eq("t2_rd0", 32'(d), 32'hFF);
    read_byte(4'd1, d); check_eq("t2_rd1", 32'(d), 32'h02);
    ack_pkt("t2");

    // 3: bad checksum, then recovery
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h01); send_byte(8'h05);
    check_eq("t3_err_pulse", 32'(err),       32'd1);
    check_eq("t3_code",      32'(err_code),  32'd2);
    check_eq("t3_no_ready",  32'(pkt_ready), 32'd0);
    @(negedge clk);
    check_eq("t3_err_one_cycle", 32'(err), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
    check_eq("t3b_ready", 32'(pkt_ready), 32'd1);
    check_eq("t3b_len",   32'(pkt_len),   32'd1);
    check_eq("t3b_code_held", 32'(err_code), 32'd2);
    read_byte(4'd0, d); check_eq("t3b_rd0", 32'(d), 32'h07);
    ack_pkt("t3b");

    // 4: junk dropped, LEN 0 and 17 rejected, LEN 16 accepted, header value as data
    send_byte(8'h00); send_byte(8'hFF);
    check_eq("t4_junk_no_err", 32'(err), 32'd0);
    send_byte(8'hA5); send_byte(8'h00);
    check_eq("t4_len0_err",  32'(err),      32'd1);
    check_eq("t4_len0_code", 32'(err_code), 32'd1);
    send_byte(8'hA5); send_byte(8'h11);
    check_eq("t4_len17_err",  32'(err),      32'd1);
    check_eq("t4_len17_code", 32'(err_code), 32'd1);
    send_byte(8'hA5); send_byte(8'h10);
    for (int unsigned i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h98);
    check_eq("t4_len16_ready", 32'(pkt_ready), 32'd1);
    check_eq("t4_len16_len",   32'(pkt_len),   32'd16);
    read_byte(4'd15, d); check_eq("t4_len16_rd15", 32'(d), 32'h10);
    ack_pkt("t4a");
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'hA6);
    check_eq("t4_hdr_data_ready", 32'(pkt_ready), 32'd1);
    read_byte(4'd0, d); check_eq("t4_hdr_data_rd0", 32'(d), 32'hA5);
    ack_pkt("t4b");

    // 5: inter-byte gap
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
`ifdef RX_PKT_TIMEOUT_EN
    repeat (99) @(negedge clk);
    check_eq("t5_no_err_cycle99", 32'(err), 32'd0);
    @(negedge clk);
    check_eq("t5_tmo_err",  32'(err),      32'd1);
    check_eq("t5_tmo_code", 32'(err_code), 32'd3);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    repeat (98) @(negedge clk);
    send_byte(8'h22);
    check_eq("t5_edge_no_err", 32'(err), 32'd0);
`else
    repeat (200) @(negedge clk);
    check_eq("t5_no_timer_no_err", 32'(err), 32'd0);
    send_byte(8'h22);
`endif
    send_byte(8'h35);
    check_eq("t5_ready", 32'(pkt_ready), 32'd1);
    read_byte(4'd1, d); check_eq("t5_rd1", 32'(d), 32'h22);
    ack_pkt("t5");

    // 6: reset mid-payload and in HOLD
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_mid");
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
    check_eq("t6_ready_before_rst", 32'(pkt_ready), 32'd1);
    read_byte(4'd0, d);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_hold");
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h05); send_byte(8'h06); send_byte(8'h0D);
    check_eq("t6_clean_ready", 32'(pkt_ready), 32'd1);
    check_eq("t6_clean_len",   32'(pkt_len),   32'd2);
    read_byte(4'd1, d); check_eq("t6_clean_rd1", 32'(d), 32'h06);
    ack_pkt("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
